// File: rtl/sh7604_intc.sv
// sh7604_intc: SH7604 interrupt controller with NMI/IRL/peripheral arbitration and an IBUS register window.
module sh7604_intc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_r,
  input  logic        ce_f,
  input  logic        en,
  input  logic        res_n,
  input  logic        nmi_n,
  input  logic [3:0]  irl_n,
  input  logic [7:0]  irl_vec,
  input  logic        divu_irq,
  input  logic [7:0]  divu_vec,
  input  logic        dmac_irq,
  input  logic [7:0]  dmac_vec,
  input  logic        wdt_irq,
  input  logic        frt_irq,
  input  logic [31:0] ibus_a,
  input  logic [31:0] ibus_di,
  output logic [31:0] ibus_do,
  input  logic [3:0]  ibus_ba,
  input  logic        ibus_we,
  input  logic        ibus_req,
  output logic        ibus_busy,
  output logic        ibus_act,
  output logic        int_req,
  output logic        int_nmi,
  output logic [3:0]  int_lvl,
  output logic [7:0]  int_vec,
  input  logic        int_ack
);
  typedef struct packed {
    logic        nmie;
    logic        vecmd;
    logic [11:0] ipra;
    logic [6:0]  vcrwdt;
    logic [3:0]  iprb;
    logic [6:0]  vcrd;
    logic        nmi_s;
    logic        nmi_v;
    logic        nmi_pend;
    logic [3:0]  irl_s1;
    logic [3:0]  irl_s2;
    logic [3:0]  irl_p;
    logic [3:0]  irl_lvl;
    logic        req;
    logic        nmi;
    logic [3:0]  lvl;
    logic [7:0]  vec;
    logic [31:0] rd;
  } state_t;

  function automatic state_t rst_state();
    state_t r;
    r = '0;
    r.nmi_s = 1'b1;
    r.irl_s1 = 4'hF;
    r.irl_s2 = 4'hF;
    r.irl_p = 4'hF;
    return r;
  endfunction

  state_t s, n;
  logic h_ee0, h_ee4, h_e60, h_e68, hit, nmi_edge, unused;
  logic [31:0] rdata;
  logic [3:0] src_lvl [5];
  logic [7:0] src_vec [5];
  logic [3:0] b_lvl;
  logic [7:0] b_vec;

  assign h_ee0 = ibus_a[31:2] == 30'h3FFFFFB8;
  assign h_ee4 = ibus_a[31:2] == 30'h3FFFFFB9;
  assign h_e60 = ibus_a[31:2] == 30'h3FFFFF98;
  assign h_e68 = ibus_a[31:2] == 30'h3FFFFF9A;
  assign hit = h_ee0 | h_ee4 | h_e60 | h_e68;
  assign unused = ^{ibus_a[1:0], ibus_di[31], ibus_di[23:17], ibus_di[3:0]};

  assign rdata = h_ee0 ? {nmi_n, 6'b0, s.nmie, 7'b0, s.vecmd, s.ipra, 4'b0} :
                 h_ee4 ? {1'b0, s.vcrwdt, 24'b0} :
                 h_e60 ? {4'b0, s.iprb, 24'b0} :
                 h_e68 ? {1'b0, s.vcrd, 24'b0} : '0;

  // No edge is reported until one post-reset sample has been taken (nmi_v).
  assign nmi_edge = s.nmi_v & (s.nmie ? (~s.nmi_s & nmi_n) : (s.nmi_s & ~nmi_n));

  assign src_lvl[0] = s.irl_lvl;
  assign src_vec[0] = s.vecmd ? irl_vec : {5'b01000, s.irl_lvl[3:1]};
  assign src_lvl[1] = divu_irq ? s.ipra[11:8] : 4'd0;
  assign src_vec[1] = divu_vec;
  assign src_lvl[2] = dmac_irq ? s.ipra[7:4] : 4'd0;
  assign src_vec[2] = dmac_vec;
  assign src_lvl[3] = wdt_irq ? s.ipra[3:0] : 4'd0;
  assign src_vec[3] = {1'b0, s.vcrwdt};
  assign src_lvl[4] = frt_irq ? s.iprb : 4'd0;
  assign src_vec[4] = {1'b0, s.vcrd};

  // Strict comparison keeps the earlier source on ties.
  always_comb begin
    b_lvl = '0;
    b_vec = '0;
    for (int i = 0; i < 5; i++) begin
      if (src_lvl[i] > b_lvl) begin
        b_lvl = src_lvl[i];
        b_vec = src_vec[i];
      end
    end
  end

  always_comb begin
    n = s;
    if (ce_r && ibus_req && ibus_we) begin
      if (h_ee0 && ibus_ba[3]) n.nmie = ibus_di[24];
      if (h_ee0 && ibus_ba[2]) n.vecmd = ibus_di[16];
      if (h_ee0 && ibus_ba[1]) n.ipra[11:4] = ibus_di[15:8];
      if (h_ee0 && ibus_ba[0]) n.ipra[3:0] = ibus_di[7:4];
      if (h_ee4 && ibus_ba[3]) n.vcrwdt = ibus_di[30:24];
      if (h_e60 && ibus_ba[3]) n.iprb = ibus_di[27:24];
      if (h_e68 && ibus_ba[3]) n.vcrd = ibus_di[30:24];
    end
    if (ce_r && en) begin
      n.nmi_s = nmi_n;
      n.nmi_v = 1'b1;
      n.nmi_pend = nmi_edge | (s.nmi_pend & ~(int_ack & s.nmi));
      n.irl_s1 = irl_n;
      n.irl_s2 = s.irl_s1;
      n.irl_p = s.irl_s2;
      n.irl_lvl = (s.irl_s2 == s.irl_p) ? ~s.irl_s2 : s.irl_lvl;
      n.req = n.nmi_pend | (b_lvl != 4'd0);
      n.nmi = n.nmi_pend;
      n.lvl = n.nmi_pend ? 4'd15 : b_lvl;
      n.vec = n.nmi_pend ? 8'd11 : b_vec;
    end
    if (ce_f) n.rd = rdata;
    if (ce_r && !res_n) n = rst_state();
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= rst_state();
    else s <= n;

  assign ibus_do = hit ? s.rd : '0;
  assign ibus_act = hit;
  assign ibus_busy = 1'b0;
  assign int_req = s.req;
  assign int_nmi = s.nmi;
  assign int_lvl = s.lvl;
  assign int_vec = s.vec;
endmodule

// File: doc/sh7604_intc.md
SH7604_INTC -- requirements
Module: SH7604_INTC

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: CLK (single clock) and RST_N (asynchronous, active-low).
REQ-002 SHALL provide these ports:
- CLK  in  1  system clock
- RST_N  in  1  async active-low reset
- CE_R  in  1  rising-phase clock enable
- CE_F  in  1  falling-phase clock enable
- EN  in  1  block enable
- RES_N  in  1  sync soft reset (power-on/manual)
- NMI_N  in  1  NMI pin
- IRL_N  in  4  external level pins
- IRL_VEC  in  8  external vector (VECMD=1)
- DIVU_IRQ/DIVU_VEC  in  1/8  divider request/vector
- DMAC_IRQ/DMAC_VEC  in  1/8  DMA request/vector
- WDT_IRQ  in  1  watchdog request
- FRT_IRQ  in  1  timer overflow request
- IBUS_A  in  32  address
- IBUS_DI  in  32  write data
- IBUS_DO  out  32  read data
- IBUS_BA  in  4  byte enables
- IBUS_WE  in  1  write
- IBUS_REQ  in  1  access request
- IBUS_BUSY  out  1  constant 0
- IBUS_ACT  out  1  register window hit
- INT_REQ  out  1  request pending to CPU
- INT_NMI  out  1  winner is NMI
- INT_LVL  out  4  winner level
- INT_VEC  out  8  winner vector
- INT_ACK  in  1  CPU acceptance pulse (one CE_R)

Function
REQ-003 SHALL decode these 16-bit registers (upper half: IBUS_BA[3:2], lower half: IBUS_BA[1:0]):
- ICR FFFFFEE0: [15] NMIL (read-only pin level), [8] NMIE, [0] VECMD
- IPRA FFFFFEE2: [15:12] DIVU, [11:8] DMAC, [7:4] WDT
- VCRWDT FFFFFEE4: [14:8] WDT vector
- IPRB FFFFFE60: [11:8] FRT
- VCRD FFFFFE68: [14:8] FRT vector
REQ-004 SHALL read as 0 all unlisted bits and all unmapped addresses.
REQ-005 SHALL assert IBUS_ACT exactly when the address hits one of the registers in REQ-003.
REQ-006 SHALL perform writes on CE_R when IBUS_REQ&IBUS_WE; reads SHALL register into IBUS_DO on CE_F; IBUS_DO SHALL be 0 when IBUS_ACT=0.
REQ-007 SHALL sample NMI_N on EN&CE_R and detect edges: falling when NMIE=0, rising when NMIE=1; a detected edge SHALL set NMI_PEND.
REQ-008 SHALL clear NMI_PEND on INT_ACK when INT_NMI=1; an edge in the same cycle as that ack SHALL leave NMI_PEND set.
REQ-009 SHALL double-synchronise IRL_N; IRL level = ~sync value; a new level SHALL be accepted only after two consecutive equal samples (noise filter).
REQ-010 IRL vector SHALL be 64+IRL_level[3:1] when VECMD=0, and IRL_VEC when VECMD=1.
REQ-011 Peripheral sources SHALL be level-sensitive with level = IPR field and vector = DIVU_VEC, DMAC_VEC, {1'b0,VCRWDT[14:8]}, {1'b0,VCRD[14:8]}; a source with level 0 SHALL be masked.
REQ-012 Arbitration SHALL select the highest level; NMI SHALL outrank all and report INT_LVL=15, INT_NMI=1, INT_VEC=11.
REQ-013 Ties SHALL resolve by fixed order IRL > DIVU > DMAC > WDT > FRT.
REQ-014 INT_REQ, INT_NMI, INT_LVL and INT_VEC SHALL be registered on EN&CE_R, with one CE_R latency from source change.
REQ-015 INT_REQ=0 SHALL force INT_LVL=0 and INT_VEC=0.
REQ-016 IPR/VCR writes SHALL affect arbitration on the next CE_R after the write.
REQ-017 INT_ACK SHALL NOT clear peripheral requests; peripherals clear their own.
REQ-018 INT_ACK while INT_REQ=0 SHALL be ignored.

Reset
REQ-019 On RST_N low (async), or on RES_N low at CE_R: all registers 0, NMI_PEND 0, sync stages 1, INT_REQ/INT_NMI/INT_LVL/INT_VEC 0, IBUS_DO 0.
REQ-020 A reset during a pending request SHALL drop INT_REQ within the same edge; no edge SHALL be detected on the first sample after reset.

Verification
REQ-021 IPRA=0xA000, DIVU_VEC=0x55, DIVU_IRQ=1 -> next CE_R: INT_REQ=1, INT_LVL=10, INT_VEC=0x55.
REQ-022 IPRA=0x5500, DIVU_IRQ and DMAC_IRQ both 1 -> DIVU wins, INT_LVL=5; set DMAC field to 6 -> DMAC wins next CE_R.
REQ-023 NMIE=0, NMI_N 1->0 -> INT_NMI=1, INT_LVL=15, INT_VEC=11; INT_ACK -> INT_REQ=0; second falling edge coincident with ack -> INT_NMI stays 1.
REQ-024 IRL_N=4'b0110 held, VECMD=0 -> level 9, vector 68; single-cycle glitch to 4'b0000 -> INT_LVL unchanged.
REQ-025 DIVU_IRQ=1 with IPRA DIVU field=0 -> INT_REQ stays 0; read of IPRA returns written value; read of ICR bit15 tracks NMI_N.
REQ-026 Assert RST_N low mid-request -> all outputs 0 immediately; release -> no spurious NMI.
